// File: rtl/regfile_mp.sv
// Multi-port integer register file with dual write, optional bypass
// and a per-register busy scoreboard for pipelined issue.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              we2,
    input  logic [AW-1:0]     wa2,
    input  logic [XLEN-1:0]   wd2,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic              bset,
    input  logic [AW-1:0]     bset_addr,
    output logic [NRD-1:0]    busy,
    output logic              busy_any
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic             wok1;
    logic             wok2;

    assign wok1 = we1 && !(ZERO_REG && wa1 == '0);
    assign wok2 = we2 && !(ZERO_REG && wa2 == '0);

    // Port 2 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wok1) regs[wa1] <= wd1;
            if (wok2) regs[wa2] <= wd2;
        end
    end

    // Writes retire the old producer first; a same-cycle issue re-marks it.
    always_comb begin
        busy_nxt = busy_q;
        if (we1) busy_nxt[wa1] = 1'b0;
        if (we2) busy_nxt[wa2] = 1'b0;
        if (bset) busy_nxt[bset_addr] = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            busy_any <= 1'b0;
        end else begin
            busy_q   <= busy_nxt;
            busy_any <= |busy_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit1;
        logic            hit2;
        logic [XLEN-1:0] val;
        logic            bsy;

        assign addr = ra[i*AW +: AW];
        assign hit1 = BYPASS && we1 && wa1 == addr;
        assign hit2 = BYPASS && we2 && wa2 == addr;

        always_comb begin
            val = regs[addr];
            bsy = busy_q[addr];
            if (hit2) begin
                val = wd2;
            end else if (hit1) begin
                val = wd1;
            end
            if (hit1 || hit2) bsy = 1'b0;
            if ((ZERO_REG && addr == '0) || rst) begin
                val = '0;
                bsy = 1'b0;
            end
        end

        assign rd[i*XLEN +: XLEN] = val;
        assign busy[i]            = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass instances share
// stimulus; expectations are queued and drained against the outputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we1, we2, bset;
    logic [4:0]  wa1, wa2, bset_addr, ra0, ra1;
    logic [31:0] wd1, wd2;
    logic [9:0]  ra;
    logic [63:0] rd, nb_rd;
    logic [1:0]  busy, nb_busy;
    logic        busy_any, nb_busy_any;

    int tests = 0;
    int fails = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          sel_q[$];

    assign ra = {ra1, ra0};

    always #10 clk = ~clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .we2(we2), .wa2(wa2), .wd2(wd2),
        .ra(ra), .rd(rd),
        .bset(bset), .bset_addr(bset_addr),
        .busy(busy), .busy_any(busy_any)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .we2(we2), .wa2(wa2), .wd2(wd2),
        .ra(ra), .rd(nb_rd),
        .bset(bset), .bset_addr(bset_addr),
        .busy(nb_busy), .busy_any(nb_busy_any)
    );

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return rd[31:0];
            1: return rd[63:32];
            2: return {31'b0, busy[0]};
            3: return {31'b0, busy[1]};
            4: return {31'b0, busy_any};
            5: return nb_rd[31:0];
            6: return nb_rd[63:32];
            7: return {31'b0, nb_busy[1]};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel,
                              input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic drain();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        #1;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = obs(s);
            tests++;
            assert (o === e) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we1  = 1'b0;
        we2  = 1'b0;
        bset = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we1 = 0; we2 = 0; bset = 0;
        wa1 = 0; wa2 = 0; bset_addr = 0;
        wd1 = 0; wd2 = 0;
        ra0 = 5'd5; ra1 = 5'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_val("rst_rd0", 0, 32'h0);
        expect_val("rst_rd1", 1, 32'h0);
        expect_val("rst_busy0", 2, 32'h0);
        expect_val("rst_busy1", 3, 32'h0);
        expect_val("rst_busy_any", 4, 32'h0);
        drain();
        // rst held high: bypass must not leak write data
        we1 = 1; wa1 = 5; wd1 = 32'h1234_5678;
        expect_val("rst_no_bypass", 0, 32'h0);
        drain();
        tick();
        rst = 1'b0;
        expect_val("rst_write_lost", 0, 32'h0);
        drain();

        we1 = 1; wa1 = 5; wd1 = 32'h1234_5678;
        expect_val("nb_r5_before", 5, 32'h0);
        expect_val("byp_r5_same", 0, 32'h1234_5678);
        drain();
        tick();
        expect_val("r5_read", 0, 32'h1234_5678);
        expect_val("nb_r5_read", 5, 32'h1234_5678);
        drain();

        we1 = 1; wa1 = 7; wd1 = 32'hCAFE_F00D;
        expect_val("byp_r7", 1, 32'hCAFE_F00D);
        expect_val("nb_r7_old", 6, 32'h0);
        drain();
        tick();
        expect_val("nb_r7_next", 6, 32'hCAFE_F00D);
        drain();

        ra0 = 5'd9;
        we1 = 1; wa1 = 9; wd1 = 32'h1111_1111;
        we2 = 1; wa2 = 9; wd2 = 32'h2222_2222;
        expect_val("byp_r9_coll", 0, 32'h2222_2222);
        drain();
        tick();
        expect_val("r9_coll", 0, 32'h2222_2222);
        expect_val("nb_r9_coll", 5, 32'h2222_2222);
        drain();

        ra0 = 5'd0;
        we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
        bset = 1; bset_addr = 0;
        expect_val("r0_byp", 0, 32'h0);
        expect_val("r0_busy_same", 2, 32'h0);
        drain();
        tick();
        expect_val("r0_rd", 0, 32'h0);
        expect_val("nb_r0_rd", 5, 32'h0);
        expect_val("r0_busy", 2, 32'h0);
        expect_val("r0_busy_any", 4, 32'h0);
        drain();

        ra1 = 5'd3;
        bset = 1; bset_addr = 3;
        expect_val("r3_busy_pre", 3, 32'h0);
        drain();
        tick();
        expect_val("r3_busy", 3, 32'h1);
        expect_val("r3_busy_any", 4, 32'h1);
        drain();
        we1 = 1; wa1 = 3; wd1 = 32'h0000_0033;
        expect_val("r3_busy_wr_byp", 3, 32'h0);
        expect_val("nb_r3_busy_wr", 7, 32'h1);
        drain();
        tick();
        expect_val("r3_busy_clr", 3, 32'h0);
        expect_val("r3_busy_any_clr", 4, 32'h0);
        drain();
        we2 = 1; wa2 = 3; wd2 = 32'h0000_0044;
        bset = 1; bset_addr = 3;
        expect_val("r3_set_wr_same", 3, 32'h0);
        drain();
        tick();
        expect_val("r3_set_wins", 3, 32'h1);
        expect_val("r3_set_any", 4, 32'h1);
        expect_val("r3_data", 1, 32'h0000_0044);
        drain();

        ra0 = 5'd4;
        we1 = 1; wa1 = 4; wd1 = 32'hA5A5_A5A5;
        bset = 1; bset_addr = 4;
        tick();
        expect_val("r4_val", 0, 32'hA5A5_A5A5);
        expect_val("r4_busy", 2, 32'h1);
        drain();
        #3;
        rst = 1'b1;
        expect_val("async_rd0", 0, 32'h0);
        expect_val("async_nb_rd0", 5, 32'h0);
        expect_val("async_busy0", 2, 32'h0);
        expect_val("async_busy1", 3, 32'h0);
        expect_val("async_busy_any", 4, 32'h0);
        drain();
        #2;
        rst = 1'b0;
        expect_val("post_rst_r4", 0, 32'h0);
        expect_val("post_rst_r3", 1, 32'h0);
        drain();

        ra1 = 5'd6;
        we1 = 1; wa1 = 6; wd1 = 32'h0BAD_BEEF;
        tick();
        expect_val("post_rst_write", 6, 32'h0BAD_BEEF);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
